// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: tracks in-flight instructions from EX onward,
// selects forwarding sources, detects load-use stalls, kills wrong-path entries on flush.
module pipe_hazard_unit #(
    parameter int ADDR_W      = 5,
    parameter int NUM_SRC     = 2,
    parameter int FWD_DEPTH   = 2,
    parameter int SEL_W       = 2,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_rs_i,
    input  logic [NUM_SRC-1:0]          id_rs_used_i,
    input  logic [ADDR_W-1:0]           id_rd_i,
    input  logic                        id_regwrite_i,
    input  logic                        id_memread_i,
    input  logic                        flush_i,
    output logic [NUM_SRC*SEL_W-1:0]    ex_fwd_sel_o,
    output logic                        ex_valid_o,
    output logic                        stall_o,
    output logic [CNT_W-1:0]            stall_cnt_o,
    output logic [CNT_W-1:0]            flush_cnt_o
);

    // Index 0 is EX, index k is k stages after EX.
    logic [FWD_DEPTH:0]            valid_q, valid_d;
    logic [FWD_DEPTH:0]            regwrite_q, regwrite_d;
    logic [ADDR_W-1:0]             rd_q [FWD_DEPTH+1];
    logic [ADDR_W-1:0]             rd_d [FWD_DEPTH+1];

    // Source fields and memread only matter while the instruction is in EX.
    logic                          ex_memread_q, ex_memread_d;
    logic [NUM_SRC*ADDR_W-1:0]     ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]            ex_rs_used_q, ex_rs_used_d;

    logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]              flush_cnt_q, flush_cnt_d;

    logic                          stall;
    logic                          rs_hit;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;

    always_comb begin
        rs_hit = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (id_rs_used_i[j] && (id_rs_i[j*ADDR_W +: ADDR_W] == rd_q[0])) begin
                rs_hit = 1'b1;
            end
        end
        stall = id_valid_i && valid_q[0] && ex_memread_q && regwrite_q[0] &&
                (rd_q[0] != '0) && rs_hit && !flush_i;
    end

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        fwd_sel = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (valid_q[0] && valid_q[k] && regwrite_q[k] && (rd_q[k] != '0) &&
                    (rd_q[k] == ex_rs_q[j*ADDR_W +: ADDR_W]) && ex_rs_used_q[j]) begin
                    fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        valid_d       = '0;
        regwrite_d    = '0;
        for (int k = 0; k <= FWD_DEPTH; k++) begin
            rd_d[k] = '0;
        end

        valid_d[0]    = id_valid_i && !flush_i && !stall;
        regwrite_d[0] = id_regwrite_i;
        rd_d[0]       = id_rd_i;
        ex_memread_d  = id_memread_i;
        ex_rs_d       = id_rs_i;
        ex_rs_used_d  = id_rs_used_i;

        for (int k = 1; k <= FWD_DEPTH; k++) begin
            valid_d[k]    = valid_q[k-1] && !(flush_i && ((k - 1) < FLUSH_DEPTH));
            regwrite_d[k] = regwrite_q[k-1];
            rd_d[k]       = rd_q[k-1];
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            regwrite_q   <= '0;
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                rd_q[k] <= '0;
            end
            ex_memread_q <= 1'b0;
            ex_rs_q      <= '0;
            ex_rs_used_q <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            ex_memread_q <= ex_memread_d;
            ex_rs_q      <= ex_rs_d;
            ex_rs_used_q <= ex_rs_used_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_fwd_sel_o = fwd_sel;
    assign ex_valid_o   = valid_q[0];
    assign stall_o      = stall;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard/forwarding controller for the pipelined CPU. It replaces the combinational forwarding unit and adds load-use stall detection, branch flush and performance counters.
- Owns a shift-register history of in-flight instructions: EX, then FWD_DEPTH later stages.
- From that history it produces per-operand forward selects for EX, a stall for PC/IF_ID, and a bubble indication for EX.

Parameters:
- ADDR_W, 5, register address width.
- NUM_SRC, 2, source operands per instruction (1..4).
- FWD_DEPTH, 2, number of stages after EX that can forward (1 = EX/MEM, 2 = MEM/WB, ...); range 1..3.
- SEL_W, 2, width of each forward select; must hold FWD_DEPTH.
- FLUSH_DEPTH, 1, number of history entries (youngest first, from EX) invalidated on flush_i; range 0..FWD_DEPTH.
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  NUM_SRC*ADDR_W  ID source addresses; source j is at [j*ADDR_W +: ADDR_W].
- id_rs_used_i  in  NUM_SRC  source j is actually read.
- id_rd_i  in  ADDR_W  ID destination.
- id_regwrite_i  in  1  ID instruction writes rd.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  branch taken (resolved in MEM), kill wrong-path instructions.
- ex_fwd_sel_o  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = result from stage k after EX.
- ex_valid_o  out  1  EX entry is valid; 0 = bubble, downstream gates controls.
- stall_o  out  1  hold PC and IF_ID this cycle.
- stall_cnt_o  out  CNT_W  count of stall cycles.
- flush_cnt_o  out  CNT_W  count of flush cycles.

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset state:
  - All history valid bits = 0; counters = 0.
  - Outputs therefore: ex_fwd_sel_o = 0, ex_valid_o = 0, stall_o = 0.
- History entry contents: {valid, regwrite, memread, rd, rs[NUM_SRC], rs_used}. Entry 0 = EX; entry k = k stages after EX (k = 1..FWD_DEPTH).
- The history shifts every cycle; downstream never back-stalls. Entry k <= entry k-1.
- Entry 0 loads on each clock, in priority order:
  1. flush_i = 1: entry 0 <= bubble. Shifted entries that came from indices < FLUSH_DEPTH get valid = 0.
  2. stall_o = 1: entry 0 <= bubble.
  3. Otherwise: entry 0 <= ID fields, with valid = id_valid_i.
- Match(k, j) is true when entry 0 is valid, AND entry k is valid with regwrite = 1, AND rd_k != 0, AND rd_k == rs_j of entry 0, AND rs_used_j = 1.
- Forward select (combinational from registers only):
  - ex_fwd_sel_o[j] = smallest k with Match(k, j), i.e. the youngest producer wins; else 0.
  - x0 is never forwarded.
  - ex_valid_o = entry 0 valid.
- Load-use stall (combinational):
  - stall_o = id_valid_i AND entry 0 valid AND entry 0 memread AND entry 0 regwrite AND rd_0 != 0 AND some j has id_rs_used_i[j] AND id_rs_j == rd_0 AND NOT flush_i.
  - A stall lasts exactly one cycle per load: the bubble clears the condition next cycle. The load then sits at k = 1 and is forwarded from stage 2 only if FWD_DEPTH >= 2.
- Loads at k = 1 are not filtered from forwarding; the stall guarantees that match never occurs with a valid consumer.
- Flush takes precedence over stall in the same cycle: stall_o = 0 and stall_cnt_o does not increment.
- Counters:
  - stall_cnt_o increments on cycles with stall_o = 1; flush_cnt_o increments on cycles with flush_i = 1.
  - Both saturate at all-ones and do not wrap.
- Reset mid-operation:
  - Next cycle, all entries are invalid and counters = 0, regardless of flush_i/stall_o.
  - Inputs sampled in the reset cycle are discarded.

Test Plan:
- Reset: assert rst_i with flush_i = 1 and id_valid_i = 1 -> next cycle ex_valid_o = 0, ex_fwd_sel_o = 0, stall_o = 0, both counters = 0.
- Back-to-back ALU dependency (add x5 <- ..., then add x6 <- x5, x5) -> when the consumer reaches EX, ex_fwd_sel_o = {1, 1}. With a one-instruction gap -> {2, 2}.
- Two producers of x7 in consecutive cycles, then a consumer of x7 -> sel = 1 (youngest wins). Destination x0 -> sel = 0.
- Load-use: lw x8 in EX, ID add reads x8 -> stall_o = 1 for exactly 1 cycle and ex_valid_o = 0 next cycle. The add then gets sel = 2; stall_cnt_o = 1.
- Flush with FLUSH_DEPTH = 1: flush_i = 1 while a load-use stall would fire -> stall_o = 0; the next two entries are invalid, so no forwarding from them; flush_cnt_o = 1, stall_cnt_o unchanged.
- Counter saturation (CNT_W = 4): hold a stall condition for 20 cycles via repeated lw/use pairs -> stall_cnt_o stops at 15.
